// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/write-back sequencer for the 16-bit CPU.
// Supports free-run and single-step modes, a halt opcode and a stretched multiply execute phase.
module instr_sequencer #(
   parameter int unsigned MEM_LAT  = 1,
   parameter int unsigned EXEC_LAT = 1,
   parameter int unsigned MULT_LAT = 4,
   parameter logic [3:0]  OP_MULT  = 4'h6,
   parameter logic [3:0]  OP_HALT  = 4'hF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run_mode,
   input  logic        step_n,
   input  logic [3:0]  codop,
   input  logic        esc_reg,
   input  logic        esc_cond_cp,
   input  logic        cond_true,
   output logic        ir_load,
   output logic        reg_read_en,
   output logic        exec_busy,
   output logic        reg_write,
   output logic        pc_write,
   output logic        pc_branch_sel,
   output logic        disp_update,
   output logic        halted,
   output logic [2:0]  state,
   output logic [15:0] instr_count
);

   localparam int unsigned LAT_A  = (MEM_LAT > EXEC_LAT) ? MEM_LAT : EXEC_LAT;
   localparam int unsigned LAT_M  = (LAT_A > MULT_LAT) ? LAT_A : MULT_LAT;
   localparam int unsigned CW     = $clog2(LAT_M + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [15:0]     count_q, count_d;
   logic            mult_q, mult_d;
   logic            sync1_q, sync2_q, prev_q;
   logic            step_pulse;
   logic            fetch_last, exec_last;

   assign step_pulse = prev_q & ~sync2_q;
   assign fetch_last = (cnt_q == CW'(MEM_LAT - 1));
   assign exec_last  = (cnt_q == (mult_q ? CW'(MULT_LAT - 1) : CW'(EXEC_LAT - 1)));

   // Phase counter restarts on every state entry and only runs in the multi-cycle states.
   always_comb begin
      cnt_d   = '0;
      count_d = count_q;
      mult_d  = mult_q;
      if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_EXEC)))
         cnt_d = cnt_q + 1'b1;
      if (state_q == S_DECODE)
         mult_d = (codop == OP_MULT);
      if (state_q == S_WB)
         count_d = count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         count_q <= '0;
         mult_q  <= 1'b0;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         count_q <= count_d;
         mult_q  <= mult_d;
         sync1_q <= step_n;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (run_mode || step_pulse) state_d = S_FETCH;
         S_FETCH:  if (fetch_last) state_d = S_DECODE;
         S_DECODE: state_d = (codop == OP_HALT) ? S_HALT : S_EXEC;
         S_EXEC:   if (exec_last) state_d = S_WB;
         S_WB:     state_d = S_IDLE;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

   // Strobes are masked while reset is asserted so an aborted instruction never retires.
   always_comb begin
      ir_load       = 1'b0;
      reg_read_en   = 1'b0;
      exec_busy     = 1'b0;
      reg_write     = 1'b0;
      pc_write      = 1'b0;
      pc_branch_sel = 1'b0;
      disp_update   = 1'b0;
      halted        = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH:  ir_load     = fetch_last;
            S_DECODE: reg_read_en = 1'b1;
            S_EXEC:   exec_busy   = 1'b1;
            S_WB: begin
               reg_write     = esc_reg;
               pc_write      = 1'b1;
               pc_branch_sel = esc_cond_cp & cond_true;
               disp_update   = 1'b1;
            end
            S_HALT:   halted      = 1'b1;
            default:  ;
         endcase
      end
   end

   assign state       = state_q;
   assign instr_count = count_q;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle control sequencer for the 16-bit CPU datapath. It steps each instruction through fetch, decode, execute and write-back. It generates the IR-load, register-read, register-write, PC-write and display-update strobes. It supports free-run and single-step (push-button) modes, a halt opcode, and a stretched execute phase for the multiplier.

Parameters:
MEM_LAT, 1, instruction-memory read latency in cycles (>=1); length of FETCH.
EXEC_LAT, 1, EXEC length in cycles for non-multiply opcodes (>=1).
MULT_LAT, 4, EXEC length in cycles when codop == OP_MULT (>=1).
OP_MULT, 4'h6, opcode that uses the multiplier.
OP_HALT, 4'hF, opcode that halts the sequencer.

Ports:
clk  in  1  system clock (the divided CPU clock).
reset  in  1  synchronous, active-high reset.
run_mode  in  1  1 = free run, 0 = single step.
step_n  in  1  raw active-low push-button; synchronized internally.
codop  in  4  opcode field of the current instruction word.
esc_reg  in  1  decoded: instruction writes the register bank.
esc_cond_cp  in  1  decoded: conditional branch.
cond_true  in  1  branch condition result from the ALU.
ir_load  out  1  latch instruction word.
reg_read_en  out  1  register-bank read strobe.
exec_busy  out  1  ALU/multiplier operating.
reg_write  out  1  register-bank write strobe.
pc_write  out  1  PC update strobe.
pc_branch_sel  out  1  1 = PC takes the branch target, 0 = PC+1.
disp_update  out  1  HEX display controller latches the result.
halted  out  1  sequencer is in HALT.
state  out  3  current state code, for debug display.
instr_count  out  16  count of retired instructions.

Behaviour:
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5. Codes 6 and 7 go to IDLE on the next cycle.
- State is a register. All strobes are decoded from the state and a cycle counter only (no combinational path from step_n).
- Reset state: state=IDLE, phase counter=0, instr_count=0, both sync flops=1, halted=0, all strobes 0. Reset wins over every other event, including mid-instruction; no strobe fires in the reset cycle or the cycle after.
- Step input: two-flop synchronizer, then falling-edge detect. This gives a 1-cycle step_pulse 3 cycles after step_n falls. A held button gives exactly one pulse. Pulses outside IDLE are dropped, not queued.
- IDLE: go to FETCH if run_mode=1 or step_pulse=1; otherwise stay. run_mode is sampled only in IDLE, so a mode change mid-instruction takes effect after WB.
- FETCH: lasts MEM_LAT cycles. ir_load=1 only in the last FETCH cycle. Then DECODE.
- DECODE: 1 cycle, reg_read_en=1. If codop==OP_HALT go to HALT, otherwise go to EXEC. codop is sampled here.
- EXEC: lasts MULT_LAT cycles if the opcode sampled in DECODE is OP_MULT, else EXEC_LAT cycles. exec_busy=1 throughout. The phase counter clears on every state entry. Then WB.
- WB: 1 cycle.
  - reg_write = esc_reg.
  - pc_write = 1.
  - pc_branch_sel = esc_cond_cp & cond_true.
  - disp_update = 1.
  - instr_count increments, wrapping 16'hFFFF to 0.
  - Next state is IDLE.
- HALT: halted=1 and all strobes 0. Stay until reset; run_mode and step_pulse are ignored. A HALT instruction is not counted and does not write the PC.
- Instruction period in free run: 3 + MEM_LAT + EXEC length (IDLE + FETCH + DECODE + EXEC + WB). With defaults this is 5 cycles, or 8 for OP_MULT.

Test Plan:
1. Free run, defaults: reset, run_mode=1, codop=4'h1, esc_reg=1 -> state sequence 0,1,2,3,4 repeating every 5 cycles; reg_write and pc_write one cycle per period; instr_count=3 after 15 cycles.
2. Multiply stretch: codop=4'h6, run_mode=1 -> exec_busy high 4 consecutive cycles; period 8 cycles; MEM_LAT=3 override gives a 10-cycle period with ir_load on the 3rd FETCH cycle only.
3. Single step: run_mode=0, step_n=1 for 50 cycles -> state stays 0, no strobes; step_n low for 40 cycles -> exactly one instruction retires (instr_count 0->1) and state returns to 0; a pulse issued during EXEC is ignored.
4. Branch select: esc_cond_cp=1, cond_true=1 -> pc_branch_sel=1 in the WB cycle; cond_true=0 -> pc_branch_sel=0 with pc_write still 1; esc_reg=0 -> reg_write stays 0.
5. Halt: after 2 normal instructions, codop=4'hF -> DECODE then HALT, halted=1, instr_count stays 2, no further strobes despite step pulses and run_mode toggles; reset -> state 0, halted=0, instr_count=0.
6. Reset mid-operation: assert reset in the 2nd EXEC cycle of an OP_MULT instruction -> next cycle state=0, instr_count=0; no reg_write or pc_write is produced for the aborted instruction.
